// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port-1 arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_DBG  = 2'd2
    } grant_t;

    localparam int unsigned MAX_WAIT_DEFAULT = 15;

    // Sign-extended when widened so address bits above 31 are kept.
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/dmem_port1_arbiter_if.sv
// Request/response and memory-side signals of the port-1 arbiter.
interface dmem_port1_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic          req0_lock;
    logic          req0_ready;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_data;

    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic          req1_ready;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_data;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0_valid, req0_addr, req0_lock,
        output req0_ready, rsp0_valid, rsp0_data,
        input  req1_valid, req1_addr,
        output req1_ready, rsp1_valid, rsp1_data,
        output mem_addr,
        input  mem_rdata
    );

    modport master (
        output req0_valid, req0_addr, req0_lock,
        input  req0_ready, rsp0_valid, rsp0_data,
        output req1_valid, req1_addr,
        input  req1_ready, rsp1_valid, rsp1_data,
        input  mem_addr,
        output mem_rdata
    );
endinterface

// File: rtl/arb_starve_counter.sv
// 8-bit saturating wait counter; hit flags that the low-priority side has waited long enough.
module arb_starve_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    input  logic [7:0] limit,
    output logic       hit
);
    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (inc && (count_q < limit)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit = (count_q == limit);

endmodule

// File: rtl/dmem_port1_arbiter.sv
// Arbitrates dmem read port 1 between the video fetcher and the debug reader;
// two-stage pipeline: address/owner stage, then response capture stage.
module dmem_port1_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int          AW       = 32,
    parameter int          DW       = 32,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    dmem_port1_arbiter_if.slave  bus
);
    localparam logic [7:0]    STARVE_LIMIT = 8'(MAX_WAIT);
    localparam logic [AW-1:0] ADDR_MASK    = AW'($signed(WORD_ALIGN_MASK));

    grant_t        grant;
    logic          starve_hit;
    logic          accept;
    logic [AW-1:0] sel_addr;

    logic [AW-1:0] addr_q,      addr_d;
    grant_t        tag_q,       tag_d;
    logic          rsp0_valid_q, rsp0_valid_d;
    logic          rsp1_valid_q, rsp1_valid_d;
    logic [DW-1:0] rsp0_data_q, rsp0_data_d;
    logic [DW-1:0] rsp1_data_q, rsp1_data_d;

    always_comb begin
        grant = GNT_NONE;
        if (bus.req0_lock && bus.req0_valid) begin
            grant = GNT_VID;
        end else if (starve_hit && bus.req1_valid && !bus.req0_lock) begin
            grant = GNT_DBG;
        end else if (bus.req0_valid) begin
            grant = GNT_VID;
        end else if (bus.req1_valid) begin
            grant = GNT_DBG;
        end
    end

    // The counter keeps running under a video lock; the forced grant waits for the lock to drop.
    arb_starve_counter u_starve (
        .clk   (clk),
        .reset (reset),
        .clear ((grant == GNT_DBG) || !bus.req1_valid),
        .inc   (bus.req1_valid && (grant != GNT_DBG)),
        .limit (STARVE_LIMIT),
        .hit   (starve_hit)
    );

    assign bus.req0_ready = bus.req0_valid && (grant == GNT_VID);
    assign bus.req1_ready = bus.req1_valid && (grant == GNT_DBG);
    assign accept         = bus.req0_ready || bus.req1_ready;
    assign sel_addr       = (grant == GNT_DBG) ? bus.req1_addr : bus.req0_addr;

    always_comb begin
        addr_d       = accept ? (sel_addr & ADDR_MASK) : addr_q;
        tag_d        = accept ? grant : GNT_NONE;

        rsp0_valid_d = (tag_q == GNT_VID);
        rsp1_valid_d = (tag_q == GNT_DBG);
        rsp0_data_d  = (tag_q == GNT_VID) ? bus.mem_rdata : rsp0_data_q;
        rsp1_data_d  = (tag_q == GNT_DBG) ? bus.mem_rdata : rsp1_data_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q       <= '0;
            tag_q        <= GNT_NONE;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
        end else begin
            addr_q       <= addr_d;
            tag_q        <= tag_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    assign bus.mem_addr   = addr_q;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_data  = rsp0_data_q;
    assign bus.rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_dmem_port1_arbiter.sv
// Bench for dmem_port1_arbiter (MAX_WAIT=3): vector table plus starvation, lock and reset sequences.
module tb_dmem_port1_arbiter;
    logic clk;
    logic reset;

    int tests;
    int fails;

    dmem_port1_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_port1_arbiter #(.AW(32), .DW(32), .MAX_WAIT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0000_0104) return 32'hCAFE_0001;
        return a ^ 32'hA5A5_0000;
    endfunction

    assign bus.mem_rdata = memword(bus.mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r0v, input logic [31:0] r0a, input logic r0l,
                         input logic r1v, input logic [31:0] r1a);
        bus.req0_valid = r0v;
        bus.req0_addr  = r0a;
        bus.req0_lock  = r0l;
        bus.req1_valid = r1v;
        bus.req1_addr  = r1a;
    endtask

    typedef struct {
        logic        r0v;
        logic [31:0] r0a;
        logic        r1v;
        logic [31:0] r1a;
        logic        rdy0;
        logic        rdy1;
        logic [31:0] maddr;
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
    } vec_t;

    vec_t vecs [9];

    int          who1, who2, k, gexp;
    logic [31:0] a1, a2, r0a, r1a;

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);

        vecs[0] = '{1'b1, 32'h104, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h104, 1'b0, 32'h0,         1'b0, 32'h0};
        vecs[2] = '{1'b0, 32'h0,   1'b1, 32'h207, 1'b0, 1'b1, 32'h104, 1'b1, 32'hCAFE_0001, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h204, 1'b0, 32'hCAFE_0001, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 32'h300, 1'b1, 32'h400, 1'b1, 1'b0, 32'h204, 1'b0, 32'hCAFE_0001, 1'b1, 32'hA5A5_0204};
        vecs[5] = '{1'b0, 32'h0,   1'b1, 32'h400, 1'b0, 1'b1, 32'h300, 1'b0, 32'hCAFE_0001, 1'b0, 32'hA5A5_0204};
        vecs[6] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h400, 1'b1, 32'hA5A5_0300, 1'b0, 32'hA5A5_0204};
        vecs[7] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h400, 1'b0, 32'hA5A5_0300, 1'b1, 32'hA5A5_0400};
        vecs[8] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h400, 1'b0, 32'hA5A5_0300, 1'b0, 32'hA5A5_0400};

        // Reset held with random inputs
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            drive(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom);
            #1;
            chk("rst_maddr", bus.mem_addr, 32'h0);
            chk("rst_v0", 32'(bus.rsp0_valid), 32'h0);
            chk("rst_v1", 32'(bus.rsp1_valid), 32'h0);
            chk("rst_d0", bus.rsp0_data, 32'h0);
            chk("rst_d1", bus.rsp1_data, 32'h0);
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("idle_maddr", bus.mem_addr, 32'h0);
            chk("idle_v0", 32'(bus.rsp0_valid), 32'h0);
            chk("idle_v1", 32'(bus.rsp1_valid), 32'h0);
            chk("idle_rdy0", 32'(bus.req0_ready), 32'h0);
            chk("idle_rdy1", 32'(bus.req1_ready), 32'h0);
            @(negedge clk);
        end

        // Vector table
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].r0v, vecs[i].r0a, 1'b0, vecs[i].r1v, vecs[i].r1a);
            #1;
            chk($sformatf("vec%0d_rdy0", i), 32'(bus.req0_ready), 32'(vecs[i].rdy0));
            chk($sformatf("vec%0d_rdy1", i), 32'(bus.req1_ready), 32'(vecs[i].rdy1));
            chk($sformatf("vec%0d_maddr", i), bus.mem_addr, vecs[i].maddr);
            chk($sformatf("vec%0d_v0", i), 32'(bus.rsp0_valid), 32'(vecs[i].v0));
            chk($sformatf("vec%0d_d0", i), bus.rsp0_data, vecs[i].d0);
            chk($sformatf("vec%0d_v1", i), 32'(bus.rsp1_valid), 32'(vecs[i].v1));
            chk($sformatf("vec%0d_d1", i), bus.rsp1_data, vecs[i].d1);
            @(negedge clk);
        end

        // Continuous contention: debug wins every fourth cycle
        who1 = 0; who2 = 0; a1 = 0; a2 = 0; k = 0;
        for (int c = 0; c < 22; c++) begin
            r0a = 32'h1000 + 32'(4 * c);
            r1a = 32'h2001 + 32'(4 * k);
            if (c < 20) begin
                drive(1, r0a, 0, 1, r1a);
                gexp = ((c % 4) == 3) ? 2 : 1;
            end else begin
                drive(0, 0, 0, 0, 0);
                gexp = 0;
            end
            #1;
            chk($sformatf("stv%0d_rdy0", c), 32'(bus.req0_ready), 32'(gexp == 1));
            chk($sformatf("stv%0d_rdy1", c), 32'(bus.req1_ready), 32'(gexp == 2));
            chk($sformatf("stv%0d_v0", c), 32'(bus.rsp0_valid), 32'(who2 == 1));
            chk($sformatf("stv%0d_v1", c), 32'(bus.rsp1_valid), 32'(who2 == 2));
            if (who2 == 1) chk($sformatf("stv%0d_d0", c), bus.rsp0_data, memword(a2));
            if (who2 == 2) chk($sformatf("stv%0d_d1", c), bus.rsp1_data, memword(a2));
            if (who1 != 0) chk($sformatf("stv%0d_maddr", c), bus.mem_addr, a1);
            who2 = who1;
            a2   = a1;
            who1 = gexp;
            a1   = ((gexp == 2) ? r1a : r0a) & 32'hFFFF_FFFC;
            if (gexp == 2) k++;
            @(negedge clk);
        end

        // Video burst lock holds off a starving debug reader
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            drive(1, 32'h3000 + 32'(4 * c), 1, 1, 32'h4000);
            #1;
            chk($sformatf("lock%0d_rdy0", c), 32'(bus.req0_ready), 32'h1);
            chk($sformatf("lock%0d_rdy1", c), 32'(bus.req1_ready), 32'h0);
            @(negedge clk);
        end
        drive(1, 32'h3100, 0, 1, 32'h4000);
        #1;
        chk("unlock_rdy0", 32'(bus.req0_ready), 32'h0);
        chk("unlock_rdy1", 32'(bus.req1_ready), 32'h1);
        @(negedge clk);
        drive(1, 32'h3100, 0, 1, 32'h4004);
        #1;
        chk("after_rdy0", 32'(bus.req0_ready), 32'h1);
        chk("after_rdy1", 32'(bus.req1_ready), 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 1, 32'h4004);
        #1;
        chk("lockrsp_v1", 32'(bus.rsp1_valid), 32'h1);
        chk("lockrsp_d1", bus.rsp1_data, 32'hA5A5_4000);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        // Reset while a video read is in flight
        drive(1, 32'h500, 0, 0, 0);
        #1;
        chk("mf_rdy0", 32'(bus.req0_ready), 32'h1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("mf_maddr_rst", bus.mem_addr, 32'h0);
        chk("mf_v0_c1", 32'(bus.rsp0_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("mf_v0_c2", 32'(bus.rsp0_valid), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        drive(1, 32'h600, 0, 0, 0);
        #1;
        chk("mf_v0_c3", 32'(bus.rsp0_valid), 32'h0);
        chk("mf_rdy0_new", 32'(bus.req0_ready), 32'h1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #1;
        chk("mf_maddr_new", bus.mem_addr, 32'h600);
        chk("mf_v0_c4", 32'(bus.rsp0_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("mf_v0_new", 32'(bus.rsp0_valid), 32'h1);
        chk("mf_d0_new", bus.rsp0_data, 32'hA5A5_0600);
        @(negedge clk);
        #1;
        chk("mf_v0_end", 32'(bus.rsp0_valid), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
